// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues reads to instruction memory,
// buffers words in a 2-entry queue for decode, and handles redirects and PC faults.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  // state | meaning
  // RUN   | issuing fetches while enabled, legal and queue has room
  // FAULT | illegal PC seen; issue halted until redirect or reset
  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

  state_t      state_q, state_d;
  logic [31:0] pc;
  logic [1:0]  count;
  logic [31:0] head_instr, head_pc, tail_instr, tail_pc;
  logic        pc_legal, pop, room, issue, fault_entry;

  assign pc_legal    = (pc[1:0] == 2'b00) && (pc <= LAST_PC);
  assign out_valid   = (count != 2'd0);
  // A redirect suppresses both the pop and the issue of its cycle.
  assign pop         = out_valid && out_ready && !redirect_valid;
  assign room        = (count < 2'd2) || pop;
  assign issue       = (state_q == RUN) && fetch_en && !redirect_valid && pc_legal && room;
  assign fault_entry = (state_q == RUN) && fetch_en && !redirect_valid && !pc_legal;

  assign imem_addr = pc;
  assign out_instr = head_instr;
  assign out_pc    = head_pc;
  assign fault     = (state_q == FAULT);

  always_comb begin
    state_d = state_q;
    if (redirect_valid)   state_d = RUN;
    else if (fault_entry) state_d = FAULT;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RUN;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      count      <= 2'd0;
      fault_pc   <= 32'd0;
      head_instr <= 32'd0;
      head_pc    <= 32'd0;
      tail_instr <= 32'd0;
      tail_pc    <= 32'd0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      count <= 2'd0;
    end else begin
      if (issue)       pc       <= pc + 32'd4;
      if (fault_entry) fault_pc <= pc;
      // Shift-form queue: head is always the oldest entry.
      case ({issue, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= imem_data;
            head_pc    <= pc;
          end else begin
            tail_instr <= imem_data;
            tail_pc    <= pc;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_instr <= imem_data;
            head_pc    <= pc;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= imem_data;
            tail_pc    <= pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed vector bench for fetch_sequencer: streaming, back-pressure, redirects,
// range/alignment faults, fetch pause and asynchronous reset.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(.RESET_PC(32'h0), .IMEM_BYTES(32)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] words [8];
  logic [7:0]  mem [32];

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr <= 32'd28)
      imem_data = {mem[imem_addr[4:0] + 5'd3], mem[imem_addr[4:0] + 5'd2],
                   mem[imem_addr[4:0] + 5'd1], mem[imem_addr[4:0]]};
  end

  typedef struct {
    logic        fe, rdy, rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, einstr;
    logic        ef;
    logic [31:0] efpc, eaddr;
  } vec_t;

  function automatic vec_t v(logic fe, logic rdy, logic rv, logic [31:0] rpc,
                             logic ev, logic [31:0] epc, logic [31:0] einstr,
                             logic ef, logic [31:0] efpc, logic [31:0] eaddr);
    vec_t r;
    r.fe = fe; r.rdy = rdy; r.rv = rv; r.rpc = rpc;
    r.ev = ev; r.epc = epc; r.einstr = einstr;
    r.ef = ef; r.efpc = efpc; r.eaddr = eaddr;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs [32];

  initial begin
    words[0] = 32'h0094_0333; words[1] = 32'h4139_03b3;
    words[2] = 32'h00a0_0093; words[3] = 32'h00b0_0113;
    words[4] = 32'h019c_1eb3; words[5] = 32'h00c0_0193;
    words[6] = 32'h00d0_0213; words[7] = 32'h00e0_0293;
    for (int i = 0; i < 8; i++)
      for (int b = 0; b < 4; b++) mem[i*4 + b] = words[i][b*8 +: 8];

    // Each record: inputs held for this cycle, outputs expected during it.
    vecs[0]  = v(1,1,0,0,     0,0,0,            0,0,  0);
    vecs[1]  = v(1,0,0,0,     1,0,words[0],     0,0,  4);
    vecs[2]  = v(1,0,0,0,     1,0,words[0],     0,0,  8);
    vecs[3]  = v(1,0,0,0,     1,0,words[0],     0,0,  8);
    vecs[4]  = v(1,0,0,0,     1,0,words[0],     0,0,  8);
    vecs[5]  = v(1,0,0,0,     1,0,words[0],     0,0,  8);
    vecs[6]  = v(1,1,0,0,     1,0,words[0],     0,0,  8);
    vecs[7]  = v(1,1,0,0,     1,4,words[1],     0,0,  12);
    vecs[8]  = v(1,1,0,0,     1,8,words[2],     0,0,  16);
    vecs[9]  = v(1,1,0,0,     1,12,words[3],    0,0,  20);
    vecs[10] = v(1,1,0,0,     1,16,words[4],    0,0,  24);
    vecs[11] = v(1,1,0,0,     1,20,words[5],    0,0,  28);
    vecs[12] = v(1,1,0,0,     1,24,words[6],    0,0,  32);
    vecs[13] = v(1,1,0,0,     1,28,words[7],    1,32, 32);
    vecs[14] = v(1,1,0,0,     0,0,0,            1,32, 32);
    vecs[15] = v(1,1,1,0,     0,0,0,            1,32, 32);
    vecs[16] = v(1,0,0,0,     0,0,0,            0,0,  0);
    vecs[17] = v(1,0,0,0,     1,0,words[0],     0,0,  4);
    vecs[18] = v(1,1,1,16,    1,0,words[0],     0,0,  8);
    vecs[19] = v(1,1,0,0,     0,0,0,            0,0,  16);
    vecs[20] = v(1,1,0,0,     1,16,words[4],    0,0,  20);
    vecs[21] = v(1,1,1,6,     1,20,words[5],    0,0,  24);
    vecs[22] = v(1,1,0,0,     0,0,0,            0,0,  6);
    vecs[23] = v(1,1,0,0,     0,0,0,            1,6,  6);
    vecs[24] = v(0,1,0,0,     0,0,0,            1,6,  6);
    vecs[25] = v(0,1,1,0,     0,0,0,            1,6,  6);
    vecs[26] = v(0,1,0,0,     0,0,0,            0,0,  0);
    vecs[27] = v(0,1,0,0,     0,0,0,            0,0,  0);
    vecs[28] = v(1,0,0,0,     0,0,0,            0,0,  0);
    vecs[29] = v(0,0,0,0,     1,0,words[0],     0,0,  4);
    vecs[30] = v(0,1,0,0,     1,0,words[0],     0,0,  4);
    vecs[31] = v(0,1,0,0,     0,0,0,            0,0,  4);

    reset_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0;
    #3;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset out_instr", out_instr, 32'd0);
    chk("reset out_pc", out_pc, 32'd0);
    chk("reset fault", {31'd0, fault}, 32'd0);
    chk("reset fault_pc", fault_pc, 32'd0);
    chk("reset imem_addr", imem_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      fetch_en = vecs[i].fe; out_ready = vecs[i].rdy;
      redirect_valid = vecs[i].rv; redirect_pc = vecs[i].rpc;
      #1;
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d fault", i), {31'd0, fault}, {31'd0, vecs[i].ef});
      chk($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].eaddr);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d out_pc", i), out_pc, vecs[i].epc);
        chk($sformatf("vec%0d out_instr", i), out_instr, vecs[i].einstr);
      end
      if (vecs[i].ef)
        chk($sformatf("vec%0d fault_pc", i), fault_pc, vecs[i].efpc);
    end

    // Asynchronous reset while a word is held at the head.
    @(negedge clk);
    fetch_en = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    chk("pre-reset out_pc", out_pc, 32'd4);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("async reset fault", {31'd0, fault}, 32'd0);
    chk("async reset imem_addr", imem_addr, 32'd0);
    chk("async reset out_pc", out_pc, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    fetch_en = 1'b1; out_ready = 1'b1;
    #1;
    chk("post-reset imem_addr", imem_addr, 32'd0);
    chk("post-reset out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("post-reset first out_valid", {31'd0, out_valid}, 32'd1);
    chk("post-reset first out_pc", out_pc, 32'd0);
    chk("post-reset first out_instr", out_instr, words[0]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
